// File: rtl/sweep_pkg.sv
// Shared types and default widths for the triangle sweep sequencer.
package sweep_pkg;

    localparam int WIDTH_D = 8;
    localparam int DIV_W_D = 4;
    localparam int REP_W_D = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } sweep_state_e;

endpackage

// File: rtl/sweep_if.sv
// Control/status bundle between the register block and the sweep sequencer.
// Optional macro SWEEP_PAUSE_EN adds the pause input.
interface sweep_if
    import sweep_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int DIV_W = DIV_W_D,
    parameter int REP_W = REP_W_D
) ();

    logic             start;
    logic             abort;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [DIV_W-1:0] div;
    logic [REP_W-1:0] reps;
`ifdef SWEEP_PAUSE_EN
    logic             pause;
`endif
    logic [WIDTH-1:0] count_out;
    logic             cnt_en;
    logic             cnt_dir;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
`ifdef SWEEP_PAUSE_EN
        output pause,
`endif
        output start, abort, lo, hi, div, reps,
        input  count_out, cnt_en, cnt_dir, busy, done, err
    );

    modport slave (
`ifdef SWEEP_PAUSE_EN
        input  pause,
`endif
        input  start, abort, lo, hi, div, reps,
        output count_out, cnt_en, cnt_dir, busy, done, err
    );

endinterface

// File: rtl/sweep_prescaler.sv
// Step-rate prescaler: counts 0..div while run is high and flags the last count.
module sweep_prescaler
    import sweep_pkg::*;
#(
    parameter int DIV_W = DIV_W_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] presc;

    assign tick = run && (presc == div);

    // Phase counter; frozen while not running so a pause resumes mid-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (clr) begin
            presc <= '0;
        end else if (run) begin
            presc <= (presc == div) ? '0 : presc + DIV_W'(1);
        end
    end

endmodule

// File: rtl/sweep_sequencer.sv
// Triangle sweep controller: ramps count_out lo->hi->lo for a programmed
// number of cycles and exports the enable/direction strobes it applies.
// Optional macro SWEEP_PAUSE_EN adds a pause input that freezes the sweep.
//
//   state | meaning
//   IDLE  | waiting for start; count_out holds its last value
//   UP    | stepping towards hi on each prescaler tick
//   DOWN  | stepping towards lo; reaching lo closes one repetition
module sweep_sequencer
    import sweep_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int DIV_W = DIV_W_D,
    parameter int REP_W = REP_W_D
) (
    input logic    clk,
    input logic    rst,
    sweep_if.slave bus
);

    sweep_state_e     state, state_n;
    logic [WIDTH-1:0] count, count_n;
    logic [REP_W-1:0] rep_cnt, rep_n;
    logic             dir, dir_n;
    logic             done_q, done_n;
    logic             err_q, err_n;
    logic [WIDTH-1:0] lo_q, hi_q;
    logic [DIV_W-1:0] div_q;
    logic [REP_W-1:0] reps_q;

    logic             accept;
    logic             busy;
    logic             paused;
    logic             tick;
    logic [WIDTH-1:0] count_inc, count_dec;
    logic [REP_W-1:0] rep_inc;

`ifdef SWEEP_PAUSE_EN
    assign paused = bus.pause;
`else
    assign paused = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign accept    = (state == IDLE) && bus.start && (bus.lo < bus.hi);
    assign count_inc = count + WIDTH'(1);
    assign count_dec = count - WIDTH'(1);
    assign rep_inc   = rep_cnt + REP_W'(1);

    sweep_prescaler #(.DIV_W(DIV_W)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .run  (busy && !paused),
        .div  (div_q),
        .tick (tick)
    );

    // Next-state and datapath decode; abort wins over a same-cycle tick.
    always_comb begin
        state_n = state;
        count_n = count;
        rep_n   = rep_cnt;
        dir_n   = dir;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (accept) begin
                        state_n = UP;
                        count_n = bus.lo;
                        rep_n   = '0;
                        dir_n   = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            UP: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (tick) begin
                    count_n = count_inc;
                    if (count_inc == hi_q) begin
                        state_n = DOWN;
                        dir_n   = 1'b0;
                    end
                end
            end
            DOWN: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (tick) begin
                    count_n = count_dec;
                    if (count_dec == lo_q) begin
                        rep_n = rep_inc;
                        // reps==0 never matches, so the counter just wraps
                        if ((reps_q != '0) && (rep_inc == reps_q)) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = UP;
                            dir_n   = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, count and configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            rep_cnt <= '0;
            dir     <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            div_q   <= '0;
            reps_q  <= '0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            rep_cnt <= rep_n;
            dir     <= dir_n;
            done_q  <= done_n;
            err_q   <= err_n;
            if (accept) begin
                lo_q   <= bus.lo;
                hi_q   <= bus.hi;
                div_q  <= bus.div;
                reps_q <= bus.reps;
            end
        end
    end

    assign bus.count_out = count;
    assign bus.cnt_en    = tick && !bus.abort;
    assign bus.cnt_dir   = dir;
    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: doc/sweep_sequencer.md
Name: sweep_sequencer

Overview:
- Controller that sequences an up/down count datapath as a programmable triangle sweep between two bounds.
- The count register is held internally. The block also exports the enable and direction strobes it applies, so downstream up/down counters can be slaved to it in lockstep.
- Started by a one-cycle request. Runs a programmed number of up/down cycles at a prescaled rate, then reports completion.
- Sits between the control registers and the count datapath that drives the display and PWM logic.

Parameters:
- WIDTH, 8, count and bound width.
- DIV_W, 4, prescaler divide field width.
- REP_W, 4, repeat-count field width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle sweep request; honoured only in IDLE.
- abort  in  1  stop the sweep; count freezes.
- lo  in  WIDTH  lower bound; sampled on an accepted start.
- hi  in  WIDTH  upper bound; sampled on an accepted start.
- div  in  DIV_W  step every div+1 clocks; sampled on start.
- reps  in  REP_W  full up/down cycles to run; 0 = run until abort.
- count_out  out  WIDTH  current sweep value.
- cnt_en  out  1  high in any cycle in which count_out changes on the next edge.
- cnt_dir  out  1  1 = counting up, 0 = counting down.
- busy  out  1  high in UP and DOWN.
- done  out  1  one-cycle pulse when the programmed reps complete.
- err  out  1  one-cycle pulse when start is rejected because lo >= hi.

Behaviour:
- Reset: state IDLE; count_out=0; cnt_en=0; cnt_dir=1; busy=0; done=0; err=0; prescaler=0; rep counter=0. Reset has priority over every other input, including mid-sweep.
- States: IDLE, UP, DOWN.
- IDLE, start=1, lo<hi:
  - latch lo, hi, div and reps;
  - count_out<=lo, prescaler<=0, rep counter<=0, cnt_dir<=1;
  - next state UP; busy=1 from the following cycle.
- IDLE, start=1, lo>=hi: err=1 for one cycle; stay in IDLE; count_out unchanged.
- start outside IDLE is ignored.
- Tick:
  - the prescaler counts 0..div, and tick=1 when prescaler==div;
  - the prescaler then wraps to 0;
  - div=0 gives a tick every cycle.
- cnt_en equals tick in UP and DOWN; it is 0 in IDLE.
- UP, on tick:
  - count_out<=count_out+1;
  - if count_out+1==hi, next state DOWN and cnt_dir<=0.
- DOWN, on tick:
  - count_out<=count_out-1;
  - if count_out-1==lo, the rep counter increments;
  - if the incremented value == reps (reps≠0): done=1 for one cycle, next state IDLE, busy<=0;
  - otherwise: next state UP and cnt_dir<=1.
- reps=0: the rep counter wraps silently; the sweep never ends without abort.
- Adjacent bounds (hi==lo+1) are legal: each half-sweep is a single step.
- Arithmetic is WIDTH-bit unsigned. Because lo<hi and the count stays within [lo,hi], no wrap-around occurs.
- abort in UP or DOWN:
  - next state IDLE; count_out holds its value;
  - busy<=0; no done pulse;
  - abort has priority over a same-cycle tick.
- abort in IDLE has no effect.
- Bound and config inputs are ignored after they are latched.
- done and err never assert in the same cycle.

Optional Feature:
- Macro SWEEP_PAUSE_EN.
- Defined: adds input port pause (1 bit).
  - While pause=1 in UP or DOWN, the prescaler and count_out freeze and cnt_en=0.
  - busy stays 1.
  - abort still overrides pause.
- Undefined: no pause port; the sweep runs uninterrupted.

Decomposition:
- Package sweep_pkg holds:
  - the state enum (IDLE, UP, DOWN);
  - default widths WIDTH_D=8, DIV_W_D=4, REP_W_D=4.
- One sub-module, sweep_prescaler:
  - ports clk, rst, clr, run, div;
  - output tick.
  - clr is driven on an accepted start. run is driven by busy, and by not-pause when the option is enabled.

Test Plan:
- Basic sweep. Stimulus: lo=2, hi=5, div=0, reps=1, start at cycle 0. Required response:
  - count_out from cycle 1 reads 2,3,4,5,4,3,2;
  - cnt_dir falls in the cycle count_out reads 5;
  - done pulses once, coincident with the final 2;
  - busy then drops and count_out holds 2.
- Prescale. Stimulus: lo=0, hi=3, div=2, reps=1. Required response:
  - each count value is held exactly 3 cycles;
  - cnt_en is high one cycle in three;
  - the sweep totals 6 steps = 18 cycles from the first UP cycle.
- Illegal start. Stimulus: lo=7, hi=7, then lo=9, hi=4. Required response: err pulses each time; busy stays 0; count_out stays unchanged.
- Abort and restart. Stimulus: reps=0, lo=10, hi=20; abort when count_out=14 during UP. Required response:
  - next cycle IDLE, count_out=14, no done;
  - a new start with lo=0, hi=1 reloads count_out=0.
- Reset mid-sweep. Stimulus: rst=1 while in DOWN with count_out=17. Required response: next cycle count_out=0, busy=0, cnt_dir=1; start during rst is ignored.
- Option built with SWEEP_PAUSE_EN. Stimulus: pause for 4 cycles at count_out=3. Required response: value held for 4 cycles, cnt_en=0, busy=1; resume continues at 4.
